mem_access_ctrl: RTL and testbench

- CPU-side initiator for the single-port synchronous RAM (9-bit address, 32-bit data, registered read data, write-over-read priority).
- Accepts one load/store request at a time from the control unit, latches it into internal MAR/MDR, drives the RAM read/write strobes, and waits out the RAM read latency.
- Returns a one-cycle done pulse; read data is held in MDR for the datapath.

---
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for a single-port synchronous RAM: latches one load/store
// into MAR/MDR, drives the RAM strobes, waits out read latency, pulses done.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wide enough for READ_LATENCY-1 up to 6.
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mar, mar_nxt;
  logic [DATA_W-1:0] mdr, mdr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              we, we_nxt;
  logic              busy_nxt, done_nxt, mem_read_nxt, mem_write_nxt;

  // State, MAR/MDR and registered strobe outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      cnt       <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state     <= state_nxt;
      mar       <= mar_nxt;
      mdr       <= mdr_nxt;
      cnt       <= cnt_nxt;
      we        <= we_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
    end
  end

  // Next-state, datapath updates, and strobes decoded from the next state so
  // the registered outputs line up with the state they belong to.
  always_comb begin
    state_nxt = state;
    mar_nxt   = mar;
    mdr_nxt   = mdr;
    cnt_nxt   = cnt;
    we_nxt    = we;

    case (state)
      IDLE: begin
        if (req) begin
          mar_nxt = req_addr;
          we_nxt  = req_we;
          if (req_we) begin
            mdr_nxt   = req_wdata;
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WRITE: state_nxt = DONE;
      READ: begin
        cnt_nxt   = CNT_W'(READ_LATENCY - 1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          if (!we) begin
            mdr_nxt = mem_rdata;
          end
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    mem_read_nxt  = (state_nxt == READ);
    mem_write_nxt = (state_nxt == WRITE);
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign rdata     = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: one instance with read
// latency 1 and one with read latency 3, each against its own RAM model.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        clear, req1, req3, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;

  logic        busy1, done1, mr1, mw1;
  logic [31:0] rdata1, mwd1, mrd1;
  logic [8:0]  ma1;
  logic        busy3, done3, mr3, mw3;
  logic [31:0] rdata3, mwd3, mrd3;
  logic [8:0]  ma3;

  logic        pl_we, pl_sel;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  logic [31:0] ram1 [0:511];
  logic [31:0] ram3 [0:511];
  logic [31:0] p3a, p3b, p3c;

  int checks = 0;
  int errors = 0;
  int ovl = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(1)) u1 (
    .clock(clock), .clear(clear), .req(req1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy1), .done(done1),
    .rdata(rdata1), .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1),
    .mem_wdata(mwd1), .mem_rdata(mrd1));

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(3)) u3 (
    .clock(clock), .clear(clear), .req(req3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy3), .done(done3),
    .rdata(rdata3), .mem_read(mr3), .mem_write(mw3), .mem_addr(ma3),
    .mem_wdata(mwd3), .mem_rdata(mrd3));

  // RAM models: write-over-read, registered read data (1 and 3 cycles).
  always @(posedge clock) begin
    if (pl_we && !pl_sel)  ram1[pl_addr] <= pl_data;
    else if (mw1)          ram1[ma1] <= mwd1;
    else if (mr1)          mrd1 <= ram1[ma1];
    if (pl_we && pl_sel)   ram3[pl_addr] <= pl_data;
    else if (mw3)          ram3[ma3] <= mwd3;
    else if (mr3)          p3a <= ram3[ma3];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mrd3 = p3c;

  always @(negedge clock) begin
    if ((mr1 && mw1) || (mr3 && mw3)) ovl <= ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [8:0] a, input logic [31:0] d);
    @(negedge clock);
    pl_we = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  // Issue one request, then watch until done (bounded); returns the cycle
  // index of done relative to the sampling edge plus strobe statistics.
  task automatic run_txn(input bit sel, input bit we, input logic [8:0] a,
                         input logic [31:0] wd, output int done_at,
                         output int rd_n, output int wr_n, output int wait_n,
                         output logic [8:0] s_addr, output logic [31:0] s_wd);
    logic b, d, r, w;
    done_at = -1; rd_n = 0; wr_n = 0; wait_n = 0; s_addr = '0; s_wd = '0;
    @(negedge clock);
    req_we = we; req_addr = a; req_wdata = wd;
    if (sel) req3 = 1'b1; else req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0; req3 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      b = sel ? busy3 : busy1;
      d = sel ? done3 : done1;
      r = sel ? mr3 : mr1;
      w = sel ? mw3 : mw1;
      if (r) begin rd_n++; s_addr = sel ? ma3 : ma1; end
      if (w) begin wr_n++; s_addr = sel ? ma3 : ma1; s_wd = sel ? mwd3 : mwd1; end
      if (b && !r && !w && !d) wait_n++;
      if (d) begin done_at = n; break; end
      @(negedge clock);
    end
  endtask

  int          dn, rn, wn, wt, cnt;
  logic [8:0]  sa;
  logic [31:0] sw;
  int          done_cyc [4];
  logic [31:0] rd_at [4];
  logic [8:0]  ma_at [4];
  bit          t_we [4];
  logic [8:0]  t_addr [4];
  logic [31:0] t_wd [4];
  int          exp_cyc [4];
  logic [31:0] exp_rd [4];
  logic [8:0]  exp_ma [4];

  initial begin
    clear = 1'b1; req1 = 1'b0; req3 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; pl_we = 1'b0; pl_sel = 1'b0;
    pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy",  32'(busy1), 32'd0);
    chk("reset_done",  32'(done1), 32'd0);
    chk("reset_strb",  32'({mr1, mw1, mr3, mw3, busy3}), 32'd0);
    chk("reset_rdata", rdata1, 32'd0);
    chk("reset_addr",  32'(ma1), 32'd0);
    chk("reset_wdata", mwd1, 32'd0);
    clear = 1'b0;

    preload(1'b0, 9'd95,  32'h0000_0004);
    preload(1'b0, 9'd94,  32'h0000_0a0a);
    preload(1'b0, 9'd42,  32'h0000_0042);
    preload(1'b0, 9'd100, 32'h0000_0064);
    preload(1'b1, 9'd200, 32'hcafe_f00d);

    // Basic load, L=1.
    run_txn(1'b0, 1'b0, 9'd95, 32'd0, dn, rn, wn, wt, sa, sw);
    chk("ld95_done_at", 32'(dn), 32'd3);
    chk("ld95_reads",   32'(rn), 32'd1);
    chk("ld95_writes",  32'(wn), 32'd0);
    chk("ld95_addr",    32'(sa), 32'd95);
    chk("ld95_wait",    32'(wt), 32'd1);
    chk("ld95_rdata",   rdata1, 32'h0000_0004);

    // Store then reload.
    run_txn(1'b0, 1'b1, 9'd87, 32'h0000_0087, dn, rn, wn, wt, sa, sw);
    chk("st87_done_at", 32'(dn), 32'd2);
    chk("st87_writes",  32'(wn), 32'd1);
    chk("st87_reads",   32'(rn), 32'd0);
    chk("st87_addr",    32'(sa), 32'd87);
    chk("st87_wdata",   sw, 32'h0000_0087);
    chk("st87_mdr",     rdata1, 32'h0000_0087);
    run_txn(1'b0, 1'b0, 9'd95, 32'd0, dn, rn, wn, wt, sa, sw);
    chk("ld95b_rdata",  rdata1, 32'h0000_0004);
    run_txn(1'b0, 1'b0, 9'd87, 32'd0, dn, rn, wn, wt, sa, sw);
    chk("ld87_done_at", 32'(dn), 32'd3);
    chk("ld87_rdata",   rdata1, 32'h0000_0087);

    // req held high: store/load at 511 then 0, back to back.
    t_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    t_addr = '{9'd511, 9'd511, 9'd0, 9'd0};
    t_wd   = '{32'ha5a5_0001, 32'd0, 32'h5a5a_0002, 32'd0};
    exp_cyc = '{2, 6, 9, 13};
    exp_rd  = '{32'ha5a5_0001, 32'ha5a5_0001, 32'h5a5a_0002, 32'h5a5a_0002};
    exp_ma  = '{9'd511, 9'd511, 9'd0, 9'd0};
    done_cyc = '{-1, -1, -1, -1};
    rd_at = '{32'd0, 32'd0, 32'd0, 32'd0};
    ma_at = '{9'd0, 9'd0, 9'd0, 9'd0};
    cnt = 0;
    @(negedge clock);
    req_we = t_we[0]; req_addr = t_addr[0]; req_wdata = t_wd[0]; req1 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done1) begin
        done_cyc[cnt] = n; rd_at[cnt] = rdata1; ma_at[cnt] = ma1;
        cnt++;
        if (cnt == 4) begin
          req1 = 1'b0;
          break;
        end
        req_we = t_we[cnt]; req_addr = t_addr[cnt]; req_wdata = t_wd[cnt];
      end
    end
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_done_at%0d", i), 32'(done_cyc[i]), 32'(exp_cyc[i]));
      chk($sformatf("b2b_rdata%0d", i), rd_at[i], exp_rd[i]);
      chk($sformatf("b2b_addr%0d", i), 32'(ma_at[i]), 32'(exp_ma[i]));
    end
    chk("ram511", ram1[511], 32'ha5a5_0001);
    chk("ram0",   ram1[0],   32'h5a5a_0002);

    // Second request while busy must be dropped.
    @(negedge clock);
    req_we = 1'b0; req_addr = 9'd94; req_wdata = 32'd0; req1 = 1'b1;
    @(negedge clock);
    req_we = 1'b1; req_addr = 9'd42; req_wdata = 32'hdead_beef;
    @(negedge clock);
    req1 = 1'b0;
    dn = -1; wn = 0;
    for (int n = 2; n <= 12; n++) begin
      if (mw1) wn++;
      if (done1 && dn < 0) dn = n;
      if (dn > 0 && n == dn) chk("busy_rdata", rdata1, 32'h0000_0a0a);
      @(negedge clock);
    end
    chk("busy_done_at", 32'(dn), 32'd3);
    chk("busy_writes",  32'(wn), 32'd0);
    chk("busy_ram42",   ram1[42], 32'h0000_0042);

    // clear during WAIT of a load.
    @(negedge clock);
    req_we = 1'b0; req_addr = 9'd100; req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clrw_busy",  32'(busy1), 32'd0);
    chk("clrw_rdata", rdata1, 32'd0);
    chk("clrw_strb",  32'({done1, mr1, mw1}), 32'd0);
    wn = 0;
    repeat (6) begin @(negedge clock); if (done1 || busy1) wn++; end
    chk("clrw_quiet", 32'(wn), 32'd0);

    // clear during WRITE still lands the write.
    @(negedge clock);
    req_we = 1'b1; req_addr = 9'd101; req_wdata = 32'h0000_1234; req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0;
    chk("clrwr_strobe", 32'(mw1), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clrwr_busy",  32'(busy1), 32'd0);
    chk("clrwr_rdata", rdata1, 32'd0);
    chk("clrwr_ram",   ram1[101], 32'h0000_1234);
    wn = 0;
    repeat (6) begin @(negedge clock); if (done1 || busy1) wn++; end
    chk("clrwr_quiet", 32'(wn), 32'd0);

    // clear and req together: request dropped.
    @(negedge clock);
    req_we = 1'b1; req_addr = 9'd7; req_wdata = 32'h77; req1 = 1'b1; clear = 1'b1;
    @(negedge clock);
    req1 = 1'b0; clear = 1'b0;
    wn = 0;
    repeat (5) begin if (busy1 || mw1 || mr1 || done1) wn++; @(negedge clock); end
    chk("clrreq_idle", 32'(wn), 32'd0);

    // Latency-3 instance.
    run_txn(1'b1, 1'b0, 9'd200, 32'd0, dn, rn, wn, wt, sa, sw);
    chk("l3_done_at", 32'(dn), 32'd5);
    chk("l3_wait",    32'(wt), 32'd3);
    chk("l3_reads",   32'(rn), 32'd1);
    chk("l3_rdata",   rdata3, 32'hcafe_f00d);

    chk("no_overlap", 32'(ovl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
